// File: rtl/relational_checker.sv
// rtl/relational_checker.sv - checks a comparator's gt/lt/eq reports against a>b, a<b, a==b
module relational_checker #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_checks,
  input  logic             valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             gt,
  input  logic             lt,
  input  logic             eq,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             error,
  output logic [CNT_W-1:0] check_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [2:0]       fail_code
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] target;
  logic [2:0]       exp_code;
  logic [2:0]       obs_code;
  logic             mismatch;
  logic [CNT_W-1:0] check_cnt_nxt;
  logic [CNT_W-1:0] err_cnt_nxt;

  always_comb begin
    exp_code      = {a > b, a < b, a == b};
    obs_code      = {gt, lt, eq};
    mismatch      = (exp_code != obs_code);
    check_cnt_nxt = check_cnt + CNT_W'(1);
    err_cnt_nxt   = err_cnt;
    if (mismatch && (err_cnt != '1)) begin
      err_cnt_nxt = err_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      target    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      error     <= 1'b0;
      check_cnt <= '0;
      err_cnt   <= '0;
      fail_a    <= '0;
      fail_b    <= '0;
      fail_code <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            target    <= num_checks;
            check_cnt <= '0;
            err_cnt   <= '0;
            error     <= 1'b0;
            fail_a    <= '0;
            fail_b    <= '0;
            fail_code <= '0;
            // An empty run completes immediately and is trivially a pass
            if (num_checks == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
              pass  <= 1'b0;
            end
          end
        end
        RUN: begin
          if (valid) begin
            check_cnt <= check_cnt_nxt;
            err_cnt   <= err_cnt_nxt;
            if (mismatch) begin
              error <= 1'b1;
              // error still clear means this is the run's first mismatch
              if (!error) begin
                fail_a    <= a;
                fail_b    <= b;
                fail_code <= obs_code;
              end
            end
            if (check_cnt_nxt == target) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_cnt_nxt == '0);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/relational_checker.md
RELATIONAL_CHECKER -- requirements
Module: relational_checker

Interface
REQ-001 Parameter WIDTH, default 1: width of operands a and b.
REQ-002 Parameter CNT_W, default 16: width of all counters and of num_checks.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  single-cycle pulse that begins a check run.
REQ-007 num_checks  input  CNT_W  number of checks in the run; latched on the accepted start.
REQ-008 valid  input  1  qualifies a, b, gt, lt and eq in the same cycle.
REQ-009 a  input  WIDTH  operand A as applied to the comparator under test.
REQ-010 b  input  WIDTH  operand B as applied to the comparator under test.
REQ-011 gt  input  1  comparator-under-test result for a>b.
REQ-012 lt  input  1  comparator-under-test result for a<b.
REQ-013 eq  input  1  comparator-under-test result for a==b.
REQ-014 busy  output  1  high while the run is in progress.
REQ-015 done  output  1  high while the run is complete.
REQ-016 pass  output  1  high in DONE when err_cnt==0.
REQ-017 error  output  1  sticky flag; set on the first mismatch of a run.
REQ-018 check_cnt  output  CNT_W  number of checks sampled in the current run.
REQ-019 err_cnt  output  CNT_W  number of mismatches in the current run; saturates at all-ones.
REQ-020 fail_a, fail_b  output  WIDTH  a and b of the first mismatching check.
REQ-021 fail_code  output  3  observed {gt,lt,eq} of the first mismatching check.

Function
REQ-022 FSM states: IDLE, RUN, DONE; the FSM SHALL encode no other states.
REQ-023 IDLE + start: latch num_checks; clear check_cnt, err_cnt, error, fail_a, fail_b and fail_code; go to RUN, or to DONE when num_checks==0.
REQ-024 DONE + start: same action as IDLE + start, so a new run begins without a reset.
REQ-025 RUN: start is ignored; a run cannot be restarted except by rst.
REQ-026 valid is ignored in IDLE and DONE, with no effect on any counter or flag.
REQ-027 RUN + valid: expected code = {a>b, a<b, a==b}, with unsigned WIDTH-bit comparison.
REQ-028 Mismatch: expected code != {gt,lt,eq}, including any multi-hot or all-zero observed code.
REQ-029 Each sampled check SHALL increment check_cnt by 1; the new value is visible one cycle after the sampling edge.
REQ-030 Mismatch: err_cnt += 1 (saturating) and error set, both visible the next cycle.
REQ-031 The fail_* capture registers SHALL load only on the first mismatch of a run and SHALL hold thereafter.
REQ-032 RUN -> DONE on the edge that samples check number num_checks; done=1 and busy=0 from the next cycle.
REQ-033 Non-consecutive valid cycles (gaps) are legal; the run ends only when num_checks checks have been sampled.
REQ-034 busy=1 exactly in RUN, done=1 exactly in DONE, and pass=done AND (err_cnt==0).
REQ-035 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-036 rst=1 at a clock edge SHALL force IDLE and clear every output and internal register to 0, including pass.
REQ-037 rst SHALL take priority over start and valid in the same cycle.
REQ-038 rst during RUN SHALL discard the partial run; start is required again to begin a new run.

Verification
REQ-039 WIDTH=1, num_checks=4, four correct vectors (00,01,10,11), valid back-to-back -> done=1 one cycle after the 4th valid, check_cnt=4, err_cnt=0, pass=1, error=0.
REQ-040 Same run with vector 2 (a=0, b=1) reported as {gt,lt,eq}=100 -> err_cnt=1, error=1, fail_a=0, fail_b=1, fail_code=100, pass=0.
REQ-041 a=1, b=1 reported as 101 followed by a second bad vector -> err_cnt=2, and fail_code stays 101 from the first mismatch.
REQ-042 start with num_checks=0 -> done=1 the next cycle, pass=1, check_cnt=0, and busy never asserts.
REQ-043 WIDTH=4, num_checks=3 with valid gaps, plus start pulsed mid-run -> start is ignored, done only after the 3rd valid, 5>3 checked as gt=1.
REQ-044 rst asserted after 2 of 4 checks -> all outputs 0 next cycle and FSM in IDLE; a fresh start gives a clean run.
